// File: rtl/cpu_run_controller.sv
// cpu_run_controller: run/halt/single-step sequencer for the Hack cpu core.
// Breakpoint support is built only when CPU_RUN_BREAKPOINT_EN is defined.
module cpu_run_controller #(
  parameter int RESET_CYCLES = 2,
  parameter int COUNT_WIDTH  = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [15:0]            step_count,
  input  logic [15:0]            pc,
  input  logic [15:0]            bp_addr,
  input  logic                   bp_valid,
  output logic                   cpu_reset,
  output logic                   cpu_enable,
  output logic                   halted,
  output logic                   break_hit,
  output logic [2:0]             state,
  output logic [COUNT_WIDTH-1:0] cycle_count
);

  localparam int RCW =
    (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES + 1);

  localparam logic [2:0] OP_RUN  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b010;
  localparam logic [2:0] OP_STEP = 3'b011;
  localparam logic [2:0] OP_RST  = 3'b100;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_HALTED = 3'd1,
    S_RUN    = 3'd2,
    S_STEP   = 3'd3,
    S_BREAK  = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [RCW-1:0]         rcnt_q, rcnt_d;
  logic [15:0]            remain_q, remain_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic accept;
  logic active;
  logic bp_match;
  logic op_run, op_halt, op_step, op_rst;

  assign accept  = cmd_valid && cmd_ready;
  assign active  = (state_q == S_RUN) || (state_q == S_STEP);
  assign op_run  = accept && (cmd_op == OP_RUN);
  assign op_halt = accept && (cmd_op == OP_HALT);
  assign op_step = accept && (cmd_op == OP_STEP);
  assign op_rst  = accept && (cmd_op == OP_RST);

`ifdef CPU_RUN_BREAKPOINT_EN
  // Suppress lets a resumed run execute the instruction it broke on.
  logic sup_q, sup_d;

  assign bp_match = active && bp_valid &&
                    (pc == bp_addr) && !sup_q;

  always_comb begin
    sup_d = sup_q;
    if (active && cpu_enable)
      sup_d = 1'b0;
    if (((state_q == S_HALTED) || (state_q == S_BREAK)) &&
        ((state_d == S_RUN) || (state_d == S_STEP)))
      sup_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset)
      sup_q <= 1'b1;
    else
      sup_q <= sup_d;
  end
`else
  logic unused_bp;

  assign bp_match  = 1'b0;
  assign unused_bp = ^{bp_valid, bp_addr, pc};
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_RESET;
      rcnt_q   <= RCW'(RESET_CYCLES);
      remain_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      rcnt_q   <= rcnt_d;
      remain_q <= remain_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    remain_d = remain_q;
    count_d  = count_q;

    if (active && cpu_enable)
      count_d = count_q + COUNT_WIDTH'(1);
    if ((state_q == S_STEP) && cpu_enable)
      remain_d = remain_q - 16'd1;

    unique case (state_q)
      S_RESET: begin
        count_d = '0;
        rcnt_d  = rcnt_q - RCW'(1);
        if (rcnt_q <= RCW'(1))
          state_d = S_HALTED;
      end
      S_HALTED, S_BREAK: begin
        if (op_run) begin
          state_d = S_RUN;
        end else if (op_step && (step_count != 16'd0)) begin
          state_d  = S_STEP;
          remain_d = step_count;
        end else if (op_halt) begin
          state_d = S_HALTED;
        end
      end
      S_RUN, S_STEP: begin
        if (op_halt) begin
          state_d  = S_HALTED;
          remain_d = '0;
        end else if (bp_match) begin
          state_d  = S_BREAK;
          remain_d = '0;
        end else if ((state_q == S_STEP) &&
                     (remain_q == 16'd1)) begin
          state_d = S_HALTED;
        end
      end
      default: state_d = S_RESET;
    endcase

    if (op_rst) begin
      state_d  = S_RESET;
      rcnt_d   = RCW'(RESET_CYCLES);
      remain_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    cpu_reset  = 1'b0;
    cpu_enable = 1'b0;
    cmd_ready  = 1'b1;
    halted     = 1'b0;
    break_hit  = 1'b0;
    unique case (state_q)
      S_RESET: begin
        cpu_reset  = 1'b1;
        cpu_enable = 1'b1;
        cmd_ready  = 1'b0;
      end
      S_HALTED: halted = 1'b1;
      S_RUN, S_STEP: cpu_enable = !bp_match;
      S_BREAK: begin
        halted    = 1'b1;
`ifdef CPU_RUN_BREAKPOINT_EN
        break_hit = 1'b1;
`endif
      end
      default: cmd_ready = 1'b0;
    endcase
  end

  assign state       = state_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Testbench for cpu_run_controller: directed scenarios plus random
// commands, checked every cycle against a behavioural model.
module tb_cpu_run_controller;

  localparam int RC = 2;
`ifdef CPU_RUN_BREAKPOINT_EN
  localparam bit BP_EN = 1'b1;
`else
  localparam bit BP_EN = 1'b0;
`endif

  localparam int ST_RESET  = 0;
  localparam int ST_HALTED = 1;
  localparam int ST_RUN    = 2;
  localparam int ST_STEP   = 3;
  localparam int ST_BREAK  = 4;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_RUN  = 3'd1;
  localparam logic [2:0] OP_HALT = 3'd2;
  localparam logic [2:0] OP_STEP = 3'd3;
  localparam logic [2:0] OP_RST  = 3'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] step_count = 16'd0;
  logic [15:0] pc = 16'd0;
  logic [15:0] bp_addr = 16'd0;
  logic        bp_valid = 1'b0;
  logic        cpu_reset, cpu_enable, halted, break_hit;
  logic [2:0]  state;
  logic [31:0] cycle_count;

  cpu_run_controller #(
    .RESET_CYCLES(RC),
    .COUNT_WIDTH(32)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .step_count(step_count),
    .pc(pc),
    .bp_addr(bp_addr),
    .bp_valid(bp_valid),
    .cpu_reset(cpu_reset),
    .cpu_enable(cpu_enable),
    .halted(halted),
    .break_hit(break_hit),
    .state(state),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model
  int          m_state;
  int          m_rleft;
  int          m_rem;
  logic [31:0] m_cnt;
  bit          m_sup;
  logic [15:0] m_pc = 16'd0;

  bit e_match, e_enable, e_reset, e_ready, e_halted, e_break;

  int dut_en_cnt, mdl_en_cnt, dut_rst_cnt, mdl_rst_cnt;

  task automatic model_reset();
    m_state = ST_RESET;
    m_rleft = RC;
    m_rem   = 0;
    m_cnt   = 32'd0;
    m_sup   = 1'b1;
  endtask

  task automatic model_outputs();
    bit running;
    running  = (m_state == ST_RUN) || (m_state == ST_STEP);
    e_match  = BP_EN && running && bp_valid &&
               (pc == bp_addr) && !m_sup;
    e_reset  = (m_state == ST_RESET);
    e_enable = e_reset || (running && !e_match);
    e_ready  = !e_reset;
    e_halted = (m_state == ST_HALTED) || (m_state == ST_BREAK);
    e_break  = (m_state == ST_BREAK);
  endtask

  task automatic model_update();
    bit acc, en_run;
    if (reset) begin
      model_reset();
      return;
    end
    acc    = cmd_valid && e_ready;
    en_run = e_enable && (m_state == ST_RUN || m_state == ST_STEP);
    if (en_run) begin
      m_cnt = m_cnt + 32'd1;
      m_sup = 1'b0;
      if (m_state == ST_STEP) m_rem = m_rem - 1;
    end
    if (acc && cmd_op == OP_RST) begin
      m_state = ST_RESET;
      m_rleft = RC;
      m_cnt   = 32'd0;
      m_rem   = 0;
    end else if (m_state == ST_RESET) begin
      m_rleft = m_rleft - 1;
      m_cnt   = 32'd0;
      if (m_rleft == 0) m_state = ST_HALTED;
    end else if (acc && cmd_op == OP_HALT) begin
      m_state = ST_HALTED;
      m_rem   = 0;
    end else if (e_match) begin
      m_state = ST_BREAK;
      m_rem   = 0;
    end else if (m_state == ST_STEP && en_run && m_rem == 0) begin
      m_state = ST_HALTED;
    end else if (acc && (m_state == ST_HALTED ||
                         m_state == ST_BREAK)) begin
      if (cmd_op == OP_RUN) begin
        m_state = ST_RUN;
        m_sup   = 1'b1;
      end else if (cmd_op == OP_STEP && step_count != 16'd0) begin
        m_state = ST_STEP;
        m_rem   = int'(step_count);
        m_sup   = 1'b1;
      end
    end
  endtask

  // One clock cycle: compare, advance model and fake CPU pc.
  task automatic tick();
    logic [15:0] pc_n, m_pc_n;
    #1;
    model_outputs();
    vectors++;
    if (state !== 3'(m_state) || cycle_count !== m_cnt ||
        cpu_enable !== e_enable || cpu_reset !== e_reset ||
        cmd_ready !== e_ready || halted !== e_halted ||
        break_hit !== e_break) begin
      miscompares++;
      $display("FAIL cycle t=%0t state %0d/%0d count %0d/%0d en %0b/%0b rst %0b/%0b rdy %0b/%0b halt %0b/%0b brk %0b/%0b (dut/required)",
        $time, state, m_state, cycle_count, m_cnt,
        cpu_enable, e_enable, cpu_reset, e_reset,
        cmd_ready, e_ready, halted, e_halted,
        break_hit, e_break);
    end
    if (cpu_enable === 1'b1) dut_en_cnt++;
    if (e_enable) mdl_en_cnt++;
    if (!reset && cpu_reset === 1'b1) dut_rst_cnt++;
    if (!reset && e_reset) mdl_rst_cnt++;
    pc_n   = (cpu_reset === 1'b1) ? 16'd0 :
             (cpu_enable === 1'b1) ? pc + 16'd1 : pc;
    m_pc_n = e_reset ? 16'd0 : e_enable ? m_pc + 16'd1 : m_pc;
    @(posedge clock);
    model_update();
    @(negedge clock);
    pc   = pc_n;
    m_pc = m_pc_n;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [15:0] sc);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    step_count = sc;
    tick();
    cmd_valid  = 1'b0;
    cmd_op     = OP_NOP;
  endtask

  task automatic pin(input string name, input logic [31:0] dut_v,
                     input logic [31:0] mdl_v, input logic [31:0] lit);
    vectors++;
    if (dut_v !== lit || mdl_v !== lit) begin
      miscompares++;
      $display("FAIL %s: dut=%0d model=%0d required=%0d",
               name, dut_v, mdl_v, lit);
    end
  endtask

  task automatic pin_regs(input string tag, input int st,
                          input int cnt);
    model_outputs();
    pin({tag, ".state"}, 32'(state), 32'(m_state), 32'(st));
    pin({tag, ".count"}, cycle_count, m_cnt, 32'(cnt));
  endtask

  initial begin
    @(posedge clock);
    model_reset();
    @(negedge clock);
    repeat (2) tick();
    reset = 1'b0;
    dut_rst_cnt = 0;
    mdl_rst_cnt = 0;
    repeat (RC) tick();
    model_outputs();
    pin("rst.reset_edges", 32'(dut_rst_cnt), 32'(mdl_rst_cnt), 32'(RC));
    pin_regs("rst", ST_HALTED, 0);
    pin("rst.halted", 32'(halted), 32'(e_halted), 32'd1);
    pin("rst.enable", 32'(cpu_enable), 32'(e_enable), 32'd0);
    pin("rst.ready", 32'(cmd_ready), 32'(e_ready), 32'd1);

    dut_en_cnt = 0;
    mdl_en_cnt = 0;
    cmd(OP_STEP, 16'd3);
    repeat (4) tick();
    pin("step3.enables", 32'(dut_en_cnt), 32'(mdl_en_cnt), 32'd3);
    pin_regs("step3", ST_HALTED, 3);
    cmd(OP_STEP, 16'd0);
    tick();
    pin_regs("step0", ST_HALTED, 3);

    cmd(OP_RST, 16'd0);
    repeat (RC) tick();
    pin_regs("rstcpu", ST_HALTED, 0);
    cmd(OP_RUN, 16'd0);
    repeat (10) tick();
    cmd(OP_HALT, 16'd0);
    pin_regs("run10", ST_HALTED, 11);
    cmd(OP_HALT, 16'd0);
    tick();
    pin_regs("halt_nop", ST_HALTED, 11);

    bp_addr  = 16'd7;
    bp_valid = 1'b1;
    cmd(OP_RST, 16'd0);
    repeat (RC) tick();
    cmd(OP_RUN, 16'd0);
    repeat (12) tick();
    model_outputs();
    if (BP_EN) begin
      pin("bp.state", 32'(state), 32'(m_state), 32'(ST_BREAK));
      pin("bp.break_hit", 32'(break_hit), 32'(e_break), 32'd1);
      pin("bp.pc", 32'(pc), 32'(m_pc), 32'd7);
      cmd(OP_RUN, 16'd0);
      tick();
      pin("resume.pc", 32'(pc), 32'(m_pc), 32'd8);
      pin("resume.state", 32'(state), 32'(m_state), 32'(ST_RUN));
    end else begin
      pin("nobp.state", 32'(state), 32'(m_state), 32'(ST_RUN));
      pin("nobp.break_hit", 32'(break_hit), 32'(e_break), 32'd0);
      pin("nobp.pc", 32'(pc), 32'(m_pc), 32'd12);
      cmd(OP_RUN, 16'd0);
      tick();
      pin("nobp2.pc", 32'(pc), 32'(m_pc), 32'd14);
      pin("nobp2.state", 32'(state), 32'(m_state), 32'(ST_RUN));
    end
    cmd(OP_HALT, 16'd0);

    cmd(OP_RST, 16'd0);
    repeat (RC) tick();
    cmd(OP_RUN, 16'd0);
    repeat (7) tick();
    cmd(OP_HALT, 16'd0);
    model_outputs();
    pin("bphalt.state", 32'(state), 32'(m_state), 32'(ST_HALTED));
    pin("bphalt.break_hit", 32'(break_hit), 32'(e_break), 32'd0);
    pin("bphalt.pc", 32'(pc), 32'(m_pc), BP_EN ? 32'd7 : 32'd8);

    bp_valid = 1'b0;
    cmd(OP_STEP, 16'd8);
    repeat (3) tick();
    cmd(OP_RST, 16'd0);
    pin_regs("stepreset", ST_RESET, 0);
    pin("stepreset.cpu_reset", 32'(cpu_reset), 32'(e_reset), 32'd1);
    repeat (RC) tick();
    pin_regs("stepreset.after", ST_HALTED, 0);
    repeat (3) tick();
    pin_regs("stepreset.idle", ST_HALTED, 0);

    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      cmd_valid  = ($urandom_range(0, 3) == 0);
      cmd_op     = 3'($urandom_range(0, 7));
      if (cmd_op == OP_RST && $urandom_range(0, 3) != 0)
        cmd_op = OP_NOP;
      step_count = ($urandom_range(0, 3) == 0) ? 16'd0 :
                   16'($urandom_range(1, 12));
      bp_valid   = 1'($urandom_range(0, 1));
      bp_addr    = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) begin
        pc   = 16'($urandom_range(0, 15));
        m_pc = pc;
      end
      tick();
    end
    reset     = 1'b0;
    cmd_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
